// File: rtl/core_pkg.sv
// Types and constants shared by the fetch stage and the decode stage that consumes F/D.
package core_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_1000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MISS  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } fd_reg_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle: instruction-cache lookup, decode stall, execute redirect and the F/D register.
interface fetch_stage_if;
    logic [31:0] ic_addr;
    logic        ic_hit;
    logic [31:0] ic_rd;
    logic        stall_d;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fd_valid;
    logic [31:0] fd_instr;
    logic [31:0] fd_pc;
    logic [31:0] fd_pc_plus4;

    modport master (
        output ic_addr, fd_valid, fd_instr, fd_pc, fd_pc_plus4,
        input  ic_hit, ic_rd, stall_d, redirect_valid, redirect_pc
    );

    modport slave (
        input  ic_addr, fd_valid, fd_instr, fd_pc, fd_pc_plus4,
        output ic_hit, ic_rd, stall_d, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/perf_counter.sv
// Saturating event counter: counts up on inc and sticks at all-ones.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, looks up the I-cache, waits out misses and fills the F/D register.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    fetch_stage_if.master    bus,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] miss_cycles
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  miss_pc_reg, miss_pc_next;
    logic [31:0]  pend_pc_reg, pend_pc_next;
    fd_reg_t      fd_reg, fd_next;

    logic             fetch_inc, miss_inc, miss_cyc_inc;
    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= RUN;
            pc_reg      <= RESET_PC;
            miss_pc_reg <= '0;
            pend_pc_reg <= '0;
            fd_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            miss_pc_reg <= miss_pc_next;
            pend_pc_reg <= pend_pc_next;
            fd_reg      <= fd_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        miss_pc_next = miss_pc_reg;
        pend_pc_next = pend_pc_reg;
        fd_next      = fd_reg;
        fetch_inc    = 1'b0;
        miss_inc     = 1'b0;
        miss_cyc_inc = 1'b0;

        case (state_reg)
            RUN: begin
                if (bus.redirect_valid) begin
                    pc_next       = bus.redirect_pc;
                    fd_next.valid = 1'b0;
                end else if (bus.stall_d) begin
                    // decode is full: PC and F/D hold
                end else if (bus.ic_hit) begin
                    fd_next   = '{valid: 1'b1, instr: bus.ic_rd, pc: pc_reg, pc_plus4: pc_reg + 32'd4};
                    pc_next   = pc_reg + 32'd4;
                    fetch_inc = 1'b1;
                end else begin
                    fd_next.valid = 1'b0;
                    miss_pc_next  = pc_reg;
                    miss_inc      = 1'b1;
                    state_next    = MISS;
                end
            end

            MISS: begin
                miss_cyc_inc = 1'b1;
                if (bus.redirect_valid) begin
                    // The refill in flight cannot be cancelled; park the target until it lands.
                    pend_pc_next  = bus.redirect_pc;
                    fd_next.valid = 1'b0;
                    state_next    = DRAIN;
                end else if (bus.ic_hit && !bus.stall_d) begin
                    fd_next    = '{valid: 1'b1, instr: bus.ic_rd, pc: pc_reg, pc_plus4: pc_reg + 32'd4};
                    pc_next    = pc_reg + 32'd4;
                    fetch_inc  = 1'b1;
                    state_next = RUN;
                end else if (bus.ic_hit) begin
                    state_next = RUN;
                end else if (!bus.stall_d) begin
                    fd_next.valid = 1'b0;
                end
            end

            DRAIN: begin
                miss_cyc_inc  = 1'b1;
                fd_next.valid = 1'b0;
                if (bus.redirect_valid) begin
                    pend_pc_next = bus.redirect_pc;
                end
                if (bus.ic_hit) begin
                    pc_next    = bus.redirect_valid ? bus.redirect_pc : pend_pc_reg;
                    state_next = RUN;
                end
            end

            default: begin
                state_next = RUN;
            end
        endcase
    end

    // During DRAIN the cache is still filling the old line, so its address must not move.
    assign bus.ic_addr     = (state_reg == DRAIN) ? miss_pc_reg : pc_reg;
    assign bus.fd_valid    = fd_reg.valid;
    assign bus.fd_instr    = fd_reg.instr;
    assign bus.fd_pc       = fd_reg.pc;
    assign bus.fd_pc_plus4 = fd_reg.pc_plus4;

    assign cnt_inc = {miss_cyc_inc, miss_inc, fetch_inc};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            perf_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign fetch_cnt   = cnt_val[0];
    assign miss_cnt    = cnt_val[1];
    assign miss_cycles = cnt_val[2];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for the main stream plus reset-in-DRAIN and PC wrap sequences.
module tb_fetch_stage;
    import core_pkg::*;

    localparam int CW = 4;  // narrow counters so saturation is reachable

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] fetch_cnt, miss_cnt, miss_cycles;
    int            checks = 0;
    int            errors = 0;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(32'h0000_1000), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .fetch_cnt   (fetch_cnt),
        .miss_cnt    (miss_cnt),
        .miss_cycles (miss_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rv;
        logic [31:0] rpc;
        bit          st;
        bit          hit;
        logic [31:0] addr;   // expected ic_addr before the edge
        bit          fdv;    // expected F/D after the edge
        logic [31:0] fdpc;
        int          fc;
        int          mc;
        int          mcy;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_0F0F;
    endfunction

    function automatic vec_t mk(bit rv, logic [31:0] rpc, bit st, bit hit, logic [31:0] addr,
                                bit fdv, logic [31:0] fdpc, int fc, int mc, int mcy);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.st = st; v.hit = hit; v.addr = addr;
        v.fdv = fdv; v.fdpc = fdpc; v.fc = fc; v.mc = mc; v.mcy = mcy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit rv, input logic [31:0] rpc, input bit st, input bit hit,
                         input logic [31:0] rd);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.stall_d        = st;
        bus.ic_hit         = hit;
        bus.ic_rd          = rd;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".ic_addr"},     bus.ic_addr, 32'h0000_1000);
        chk({tag, ".fd_valid"},    32'(bus.fd_valid), 32'd0);
        chk({tag, ".fd_instr"},    bus.fd_instr, 32'd0);
        chk({tag, ".fd_pc"},       bus.fd_pc, 32'd0);
        chk({tag, ".fd_pc_plus4"}, bus.fd_pc_plus4, 32'd0);
        chk({tag, ".fetch_cnt"},   32'(fetch_cnt), 32'd0);
        chk({tag, ".miss_cnt"},    32'(miss_cnt), 32'd0);
        chk({tag, ".miss_cycles"}, 32'(miss_cycles), 32'd0);
    endtask

    initial begin
        // 4 hits from reset PC
        vecs.push_back(mk(0, 0, 0, 1, 32'h1000, 1, 32'h1000, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h1004, 1, 32'h1004, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h1008, 1, 32'h1008, 3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h100C, 1, 32'h100C, 4, 0, 0));
        // miss at 0x1010: hit low 10 cycles, fill on the 11th
        vecs.push_back(mk(0, 0, 0, 0, 32'h1010, 0, 0, 4, 1, 0));
        for (int i = 1; i <= 9; i++)
            vecs.push_back(mk(0, 0, 0, 0, 32'h1010, 0, 0, 4, 1, i));
        vecs.push_back(mk(0, 0, 0, 1, 32'h1010, 1, 32'h1010, 5, 1, 10));
        // stall for 3 cycles in a hit stream
        vecs.push_back(mk(0, 0, 0, 1, 32'h1014, 1, 32'h1014, 6, 1, 10));
        vecs.push_back(mk(0, 0, 1, 1, 32'h1018, 1, 32'h1014, 6, 1, 10));
        vecs.push_back(mk(0, 0, 1, 1, 32'h1018, 1, 32'h1014, 6, 1, 10));
        vecs.push_back(mk(0, 0, 1, 1, 32'h1018, 1, 32'h1014, 6, 1, 10));
        vecs.push_back(mk(0, 0, 0, 1, 32'h1018, 1, 32'h1018, 7, 1, 10));
        // redirect together with stall in RUN
        vecs.push_back(mk(1, 32'h4000, 1, 1, 32'h101C, 0, 0, 7, 1, 10));
        vecs.push_back(mk(0, 0, 0, 1, 32'h4000, 1, 32'h4000, 8, 1, 10));
        // miss at 0x4004, redirect on 3rd MISS cycle, second redirect in DRAIN
        vecs.push_back(mk(0, 0, 0, 0, 32'h4004, 0, 0, 8, 2, 10));
        vecs.push_back(mk(0, 0, 0, 0, 32'h4004, 0, 0, 8, 2, 11));
        vecs.push_back(mk(0, 0, 0, 0, 32'h4004, 0, 0, 8, 2, 12));
        vecs.push_back(mk(1, 32'h2000, 0, 0, 32'h4004, 0, 0, 8, 2, 13));
        vecs.push_back(mk(0, 0, 0, 0, 32'h4004, 0, 0, 8, 2, 14));
        vecs.push_back(mk(1, 32'h3000, 0, 0, 32'h4004, 0, 0, 8, 2, 15));
        vecs.push_back(mk(0, 0, 0, 0, 32'h4004, 0, 0, 8, 2, 15));
        vecs.push_back(mk(0, 0, 0, 1, 32'h4004, 0, 0, 8, 2, 15));  // stale fill discarded
        vecs.push_back(mk(0, 0, 0, 1, 32'h3000, 1, 32'h3000, 9, 2, 15));
        // hit stream until fetch_cnt saturates
        for (int i = 1; i <= 7; i++)
            vecs.push_back(mk(0, 0, 0, 1, 32'h3000 + 32'(4 * i), 1, 32'h3000 + 32'(4 * i),
                              (9 + i > 15) ? 15 : 9 + i, 2, 15));

        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_state("reset");

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            string tag;
            v = vecs[i];
            tag = $sformatf("v%0d", i);
            drive(v.rv, v.rpc, v.st, v.hit, instr_of(v.addr));
            #1;
            chk({tag, ".ic_addr"}, bus.ic_addr, v.addr);
            @(posedge clk);
            #1;
            chk({tag, ".fd_valid"}, 32'(bus.fd_valid), 32'(v.fdv));
            if (v.fdv) begin
                chk({tag, ".fd_pc"},       bus.fd_pc, v.fdpc);
                chk({tag, ".fd_instr"},    bus.fd_instr, instr_of(v.fdpc));
                chk({tag, ".fd_pc_plus4"}, bus.fd_pc_plus4, v.fdpc + 32'd4);
            end
            chk({tag, ".fetch_cnt"},   32'(fetch_cnt), 32'(v.fc));
            chk({tag, ".miss_cnt"},    32'(miss_cnt), 32'(v.mc));
            chk({tag, ".miss_cycles"}, 32'(miss_cycles), 32'(v.mcy));
            $display("vec %0d: addr=%h fd_valid=%0d fd_pc=%h cnt=%0d/%0d/%0d",
                     i, v.addr, bus.fd_valid, bus.fd_pc, fetch_cnt, miss_cnt, miss_cycles);
            @(negedge clk);
        end

        // reset asserted asynchronously while in DRAIN
        drive(0, 0, 0, 0, 0);                      // RUN miss at 0x3020 -> MISS
        @(posedge clk); @(negedge clk);
        drive(1, 32'h5000, 0, 0, 0);               // MISS -> DRAIN
        @(posedge clk); @(negedge clk);
        drive(0, 0, 0, 1, instr_of(32'h1000));     // stale fill arriving across reset
        #1;
        chk("drain.ic_addr", bus.ic_addr, 32'h3020);
        reset = 1'b1;
        #1;
        chk_reset_state("async_reset");
        $display("seq reset-in-DRAIN: ic_addr=%h fd_valid=%0d", bus.ic_addr, bus.fd_valid);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset.fd_valid", 32'(bus.fd_valid), 32'd1);
        chk("post_reset.fd_pc",    bus.fd_pc, 32'h1000);
        chk("post_reset.fd_instr", bus.fd_instr, instr_of(32'h1000));
        chk("post_reset.fetch_cnt", 32'(fetch_cnt), 32'd1);
        $display("seq post-reset hit: fd_pc=%h fetch_cnt=%0d", bus.fd_pc, fetch_cnt);

        // PC wrap at the top of the address space
        @(negedge clk);
        drive(1, 32'hFFFF_FFFC, 0, 0, 0);
        @(posedge clk); @(negedge clk);
        drive(0, 0, 0, 1, instr_of(32'hFFFF_FFFC));
        #1;
        chk("wrap.ic_addr_top", bus.ic_addr, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        chk("wrap.fd_pc",       bus.fd_pc, 32'hFFFF_FFFC);
        chk("wrap.fd_pc_plus4", bus.fd_pc_plus4, 32'h0000_0000);
        chk("wrap.ic_addr",     bus.ic_addr, 32'h0000_0000);
        $display("seq wrap: fd_pc=%h fd_pc_plus4=%h ic_addr=%h", bus.fd_pc, bus.fd_pc_plus4, bus.ic_addr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the multicycle/pipelined core; sits directly upstream of the direct-mapped instruction cache (4 lines x 16 B, 10-cycle refill).
- Owns the PC and drives the cache address; consumes the cache hit flag and read word.
- Stalls on misses, accepts branch redirects from execute and fills the F/D pipeline register consumed by decode.
- Keeps fetch and miss performance counters.

Parameters:
RESET_PC, 32'h0000_1000, PC value loaded on reset
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-high reset
ic_addr  out  32  byte address presented to the instruction cache
ic_hit  in  1  cache hit / fill-complete for ic_addr
ic_rd  in  32  instruction word from the cache, valid when ic_hit=1
stall_d  in  1  decode cannot accept a new F/D entry this cycle
redirect_valid  in  1  taken branch/jump from execute
redirect_pc  in  32  redirect target, word-aligned
fd_valid  out  1  F/D register holds a valid instruction
fd_instr  out  32  fetched instruction
fd_pc  out  32  PC of fd_instr
fd_pc_plus4  out  32  fd_pc + 4
fetch_cnt  out  CNT_W  instructions delivered to F/D
miss_cnt  out  CNT_W  misses detected in RUN
miss_cycles  out  CNT_W  cycles spent in MISS or DRAIN

Behaviour:
- Reset (async):
  - pc = RESET_PC, state = RUN.
  - fd_valid = 0; fd_instr, fd_pc, fd_pc_plus4 = 0.
  - All counters = 0; pend_pc = 0.
- ic_addr is combinational: equals pc in RUN/MISS and miss_pc in DRAIN. It must never change while a refill is outstanding.
- State machine has three states: RUN, MISS, DRAIN. Rules are evaluated in the priority order listed.
- RUN:
  - redirect_valid: pc <= redirect_pc; fd_valid <= 0; stay in RUN.
  - else stall_d: hold pc and the F/D register; no counter changes.
  - else ic_hit: fd_instr <= ic_rd, fd_pc <= pc, fd_pc_plus4 <= pc+4, fd_valid <= 1; pc <= pc+4; fetch_cnt++.
  - else (miss): fd_valid <= 0 (bubble); miss_pc <= pc; miss_cnt++; go to MISS.
- MISS (miss_cycles++ every cycle):
  - redirect_valid: pend_pc <= redirect_pc; fd_valid <= 0; go to DRAIN.
  - else ic_hit && !stall_d: capture into F/D exactly as in RUN; pc <= pc+4; go to RUN.
  - else ic_hit && stall_d: F/D held; go to RUN (line is resident, RUN re-hits).
  - else: stay in MISS; fd_valid keeps its value if stall_d, otherwise 0.
- DRAIN (miss_cycles++ every cycle): waits out the stale refill.
  - redirect_valid: pend_pc <= redirect_pc; the latest redirect wins.
  - ic_hit: discard ic_rd; pc <= pend_pc, or redirect_pc if redirect_valid in the same cycle; go to RUN.
  - fd_valid stays 0.
- Redirect + stall_d in the same cycle: the redirect wins and the F/D entry is flushed.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0 with no error.
- Counters saturate at all-ones and do not wrap.
- Reset mid-MISS/DRAIN:
  - Immediate return to RUN at RESET_PC.
  - Any stale ic_hit after reset is treated as an ordinary RUN lookup of RESET_PC.
- Latency: a hit delivers to F/D one cycle after the address is presented. A miss costs the refill time plus 1 cycle; DRAIN adds one extra lookup.
- fd_pc_plus4 is registered, not recomputed combinationally.

Decomposition:
- Shared package core_pkg:
  - fetch_state_t enum {RUN, MISS, DRAIN}.
  - fd_reg_t packed struct {valid, instr[31:0], pc[31:0], pc_plus4[31:0]}, reused by decode.
  - Constant DEFAULT_RESET_PC.
- One natural sub-module: perf_counter (saturating CNT_W counter with increment enable and async reset), instantiated three times.

Test Plan:
- Reset, then 4 hits from RESET_PC=0x1000 with stall_d=0 -> F/D shows pc 0x1000,0x1004,0x1008,0x100C on consecutive cycles; fetch_cnt=4.
- Miss at 0x1010, ic_hit held low 10 cycles -> fd_valid=0 throughout, ic_addr stays 0x1010; then instruction delivered with fd_pc=0x1010; miss_cnt=1, miss_cycles=10.
- Redirect to 0x2000 on the 3rd MISS cycle, then second redirect to 0x3000 before fill -> ic_addr holds the old miss address until ic_hit; stale word discarded; next lookup at 0x3000; fd_valid never 1 for the stale word.
- stall_d=1 for 3 cycles during hit stream -> pc and F/D frozen, fetch_cnt unchanged; resumes with the next sequential pc.
- redirect_valid and stall_d asserted together in RUN -> fd_valid=0 next cycle, pc=redirect_pc.
- Assert reset during DRAIN -> all outputs at reset values immediately; state RUN, pc=0x1000; pc at 0xFFFF_FFFC with hit -> pc wraps to 0x0.
